// File: rtl/stopwatch_ctrl_mc.sv
// Multi-channel stopwatch/timer control: button edge detection, channel select,
// and one STOP/RUN/LAP/CLEAR state machine per channel with expiry alarm.
module stopwatch_ctrl_mc #(
  parameter int N_CH  = 2,
  parameter int CH_W  = 1,
  parameter int CLR_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_L,
  input  logic            btn_R,
  input  logic            btn_U,
  input  logic            btn_D,
  input  logic [N_CH-1:0] expire,
  output logic [N_CH-1:0] run,
  output logic [N_CH-1:0] clear,
  output logic [N_CH-1:0] lap_hold,
  output logic [N_CH-1:0] dir_down,
  output logic [N_CH-1:0] alarm,
  output logic [CH_W-1:0] ch_sel
);

  localparam int CNT_W = (CLR_W > 1) ? $clog2(CLR_W) : 1;

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_LAP, ST_CLEAR} state_t;

  logic [3:0] btn_now;
  logic [3:0] btn_prev_reg;
  logic [3:0] btn_ev;
  logic       ev_l, ev_r, ev_u, ev_d;

  logic [CH_W-1:0] ch_sel_reg, ch_sel_next;

  assign btn_now = {btn_D, btn_U, btn_R, btn_L};
  assign btn_ev  = btn_now & ~btn_prev_reg;
  assign ev_l    = btn_ev[0];
  assign ev_r    = btn_ev[1];
  assign ev_u    = btn_ev[2];
  assign ev_d    = btn_ev[3];

  // History resets to 1 so a button already held when reset releases is not an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev_reg <= 4'b1111;
      ch_sel_reg   <= '0;
    end else begin
      btn_prev_reg <= btn_now;
      ch_sel_reg   <= ch_sel_next;
    end
  end

  always_comb begin
    ch_sel_next = ch_sel_reg;
    if (ev_u) begin
      ch_sel_next = (ch_sel_reg == CH_W'(N_CH - 1)) ? '0 : ch_sel_reg + 1'b1;
    end
  end

  assign ch_sel = ch_sel_reg;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             dir_reg, dir_next;
      logic             alarm_reg, alarm_next;
      logic             run_reg, run_next;
      logic             clear_reg, clear_next;
      logic             lap_reg, lap_next;
      logic             sel, r_ev, l_ev, d_ev, expire_hit;

      // Events decode against the pre-increment selection so a simultaneous U
      // lands the L/R/D action on the previously selected channel.
      assign sel  = (ch_sel_reg == CH_W'(gi));
      assign r_ev = sel & ev_r;
      assign l_ev = sel & ev_l;
      assign d_ev = sel & ev_d;
      assign expire_hit = expire[gi] & dir_reg &
                          ((state_reg == ST_RUN) || (state_reg == ST_LAP));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= ST_STOP;
          cnt_reg   <= '0;
          dir_reg   <= 1'b0;
          alarm_reg <= 1'b0;
          run_reg   <= 1'b0;
          clear_reg <= 1'b0;
          lap_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          dir_reg   <= dir_next;
          alarm_reg <= alarm_next;
          run_reg   <= run_next;
          clear_reg <= clear_next;
          lap_reg   <= lap_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        alarm_next = alarm_reg;
        if (expire_hit) begin
          state_next = ST_STOP;
          alarm_next = 1'b1;
        end else begin
          case (state_reg)
            ST_STOP: begin
              if (r_ev) begin
                state_next = ST_RUN;
                alarm_next = 1'b0;
              end else if (l_ev) begin
                state_next = ST_CLEAR;
                cnt_next   = CNT_W'(CLR_W - 1);
                alarm_next = 1'b0;
              end else if (d_ev) begin
                dir_next = ~dir_reg;
              end
            end
            ST_RUN: begin
              if (r_ev) begin
                state_next = ST_STOP;
                alarm_next = 1'b0;
              end else if (l_ev) begin
                state_next = ST_LAP;
                alarm_next = 1'b0;
              end
            end
            ST_LAP: begin
              if (r_ev) begin
                state_next = ST_STOP;
                alarm_next = 1'b0;
              end else if (l_ev) begin
                state_next = ST_RUN;
                alarm_next = 1'b0;
              end
            end
            default: begin
              if (cnt_reg == '0) begin
                state_next = ST_STOP;
              end else begin
                cnt_next = cnt_reg - 1'b1;
              end
            end
          endcase
        end
      end

      // Outputs are decoded from the next state and registered alongside it.
      always_comb begin
        run_next   = (state_next == ST_RUN) || (state_next == ST_LAP);
        clear_next = (state_next == ST_CLEAR);
        lap_next   = (state_next == ST_LAP);
      end

      assign run[gi]      = run_reg;
      assign clear[gi]    = clear_reg;
      assign lap_hold[gi] = lap_reg;
      assign dir_down[gi] = dir_reg;
      assign alarm[gi]    = alarm_reg;
    end
  endgenerate

endmodule

// File: tb/tb_stopwatch_ctrl_mc.sv
// Scoreboard bench for stopwatch_ctrl_mc: expected outputs are queued with each
// stimulus cycle and compared one cycle later against the DUT.
module tb_stopwatch_ctrl_mc;

  localparam int N_CH  = 3;
  localparam int CH_W  = 2;
  localparam int CLR_W = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            btn_L = 1'b0, btn_R = 1'b0, btn_U = 1'b0, btn_D = 1'b0;
  logic [N_CH-1:0] expire = '0;
  logic [N_CH-1:0] run, clear, lap_hold, dir_down, alarm;
  logic [CH_W-1:0] ch_sel;

  stopwatch_ctrl_mc #(.N_CH(N_CH), .CH_W(CH_W), .CLR_W(CLR_W)) dut (
    .clk(clk), .rst(rst),
    .btn_L(btn_L), .btn_R(btn_R), .btn_U(btn_U), .btn_D(btn_D),
    .expire(expire),
    .run(run), .clear(clear), .lap_hold(lap_hold),
    .dir_down(dir_down), .alarm(alarm), .ch_sel(ch_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0] run;
    logic [N_CH-1:0] clr;
    logic [N_CH-1:0] lap;
    logic [N_CH-1:0] dir;
    logic [N_CH-1:0] alm;
    logic [CH_W-1:0] sel;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  exp_t  e;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic pop_compare();
    exp_t  x;
    string t;
    if (sb_q.size() == 0) begin
      check("sb_empty", 8'd1, 8'd0);
      return;
    end
    x = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".run"},      8'(run),      8'(x.run));
    check({t, ".clear"},    8'(clear),    8'(x.clr));
    check({t, ".lap_hold"}, 8'(lap_hold), 8'(x.lap));
    check({t, ".dir_down"}, 8'(dir_down), 8'(x.dir));
    check({t, ".alarm"},    8'(alarm),    8'(x.alm));
    check({t, ".ch_sel"},   8'(ch_sel),   8'(x.sel));
    $display("txn %-14s run=%b clr=%b lap=%b dir=%b alm=%b sel=%0d",
             t, run, clear, lap_hold, dir_down, alarm, ch_sel);
  endtask

  // One clock: queue the expectation, let the edge happen, compare just after it.
  task automatic cyc(input string tag);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    pop_compare();
  endtask

  // Asynchronous reset check: outputs must drop without waiting for an edge.
  task automatic async_rst(input string tag);
    #2;
    rst = 1'b1;
    e = '0;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    pop_compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    e = '0;
    cyc("reset");
    rst = 1'b0;
    cyc("idle");

    // Start/stop channel 0, including a held button producing a single event.
    btn_R = 1; e.run = 3'b001; cyc("r_start");
    cyc("r_held");
    btn_R = 0; cyc("r_release");
    btn_R = 1; e.run = 3'b000; cyc("r_stop");
    btn_R = 0; cyc("r_idle");

    // Clear lasts exactly 3 cycles and ignores buttons.
    btn_L = 1; e.clr = 3'b001; cyc("clr_1");
    btn_L = 0; btn_R = 1; cyc("clr_2");
    btn_R = 0; cyc("clr_3");
    e.clr = 3'b000; cyc("clr_done");
    cyc("clr_after");

    // Lap sequence, plus expire ignored while counting up.
    btn_R = 1; e.run = 3'b001; cyc("lap_run");
    btn_R = 0; expire = 3'b001; cyc("exp_up_ign");
    expire = 3'b000;
    btn_L = 1; e.lap = 3'b001; cyc("lap_on");
    btn_L = 0; cyc("lap_rel");
    btn_L = 1; e.lap = 3'b000; cyc("lap_off");
    btn_L = 0; cyc("lap_rel2");
    btn_L = 1; e.lap = 3'b001; cyc("lap_on2");
    btn_L = 0; cyc("lap_rel3");
    btn_R = 1; e.lap = 3'b000; e.run = 3'b000; cyc("lap_stop");
    btn_R = 0; cyc("lap_idle");

    // Down-count expiry with alarm.
    btn_D = 1; e.dir = 3'b001; cyc("dir_down");
    btn_D = 0; expire = 3'b001; cyc("exp_stop_ign");
    expire = 3'b000;
    btn_R = 1; e.run = 3'b001; cyc("dn_run");
    btn_R = 0; cyc("dn_rel");
    btn_L = 1; expire = 3'b001; e.run = 3'b000; e.alm = 3'b001; cyc("expire");
    btn_L = 0; expire = 3'b000; cyc("exp_rel");
    btn_R = 1; e.run = 3'b001; e.alm = 3'b000; cyc("alm_clr");
    btn_R = 0; cyc("alm_rel");
    btn_R = 1; e.run = 3'b000; cyc("dn_stop");
    btn_R = 0; cyc("dn_idle");

    // Channel selection wrap and independent channels.
    btn_U = 1; e.sel = 2'd1; cyc("sel_1");
    btn_U = 0; cyc("sel_rel");
    btn_U = 1; e.sel = 2'd2; cyc("sel_2");
    btn_U = 0; cyc("sel_rel");
    btn_U = 1; e.sel = 2'd0; cyc("sel_0");
    btn_U = 0; cyc("sel_rel");
    btn_U = 1; e.sel = 2'd1; cyc("sel_1b");
    btn_U = 0; cyc("sel_rel");
    btn_R = 1; e.run = 3'b010; cyc("ch1_run");
    btn_R = 0; cyc("ch1_rel");
    btn_U = 1; e.sel = 2'd2; cyc("sel_2b");
    btn_U = 0; cyc("sel_rel");
    btn_R = 1; e.run = 3'b110; cyc("ch2_run");
    btn_R = 0; cyc("ch2_rel");
    btn_U = 1; btn_R = 1; e.sel = 2'd0; e.run = 3'b010; cyc("u_and_r");
    btn_U = 0; btn_R = 0; cyc("ur_rel");

    // Reset mid-LAP on channel 1.
    btn_U = 1; e.sel = 2'd1; cyc("sel_1c");
    btn_U = 0; cyc("sel_rel");
    btn_L = 1; e.lap = 3'b010; cyc("ch1_lap");
    btn_L = 0;
    async_rst("rst_mid_lap");
    cyc("in_rst");
    rst = 1'b0;
    cyc("rst_rel");

    // Reset mid-CLEAR, with R held across reset release.
    btn_L = 1; e.clr = 3'b001; cyc("clr_again");
    btn_L = 0; btn_R = 1;
    async_rst("rst_mid_clr");
    cyc("in_rst2");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc($sformatf("held_%0d", i));
    btn_R = 0; cyc("held_rel");
    btn_R = 1; e.run = 3'b001; cyc("post_rst_run");
    btn_R = 0; cyc("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl_mc.md
STOPWATCH_CTRL_MC -- requirements
Module: stopwatch_ctrl_mc

Interface
REQ-001 The block SHALL have parameter N_CH, default 2, number of independent stopwatch/timer channels (1..8).
REQ-002 The block SHALL have parameter CH_W, default 1, width of the channel-select index (must satisfy 2^CH_W >= N_CH).
REQ-003 The block SHALL have parameter CLR_W, default 1, clear pulse length in clk cycles (>= 1).
REQ-004 The block SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port btn_L, btn_R, btn_U, btn_D  input  1 each  debounced level buttons.
REQ-007 The block SHALL have port expire  input  N_CH  per-channel "down-count reached zero" flag from datapath.
REQ-008 The block SHALL have port run  output  N_CH  channel counting enable (state RUN or LAP).
REQ-009 The block SHALL have port clear  output  N_CH  counter clear, high while channel in CLEAR.
REQ-010 The block SHALL have port lap_hold  output  N_CH  display freeze, high while channel in LAP.
REQ-011 The block SHALL have port dir_down  output  N_CH  count direction, 1 = count down.
REQ-012 The block SHALL have port alarm  output  N_CH  sticky expiry indicator.
REQ-013 The block SHALL have port ch_sel  output  CH_W  currently selected channel index.

Function
REQ-014 Each button SHALL produce a one-cycle event when sampled high at an edge after being sampled low at the previous edge; a held button SHALL produce exactly one event.
REQ-015 All outputs SHALL be registered; state and outputs SHALL update at the same edge that samples the event (1-cycle latency from button rise to output change).
REQ-016 btn_U events SHALL increment ch_sel, wrapping from N_CH-1 to 0; no other button changes ch_sel.
REQ-017 btn_L, btn_R, btn_D events SHALL act only on channel ch_sel; unselected channels SHALL continue their current state unaffected.
REQ-018 Per-channel FSM states SHALL be STOP, RUN, LAP, CLEAR.
REQ-019 STOP: R -> RUN; else L -> CLEAR; else D -> toggle dir_down, stay STOP; R and L in same cycle -> R wins.
REQ-020 RUN: R -> STOP; else L -> LAP; D ignored.
REQ-021 LAP: R -> STOP (lap_hold drops); else L -> RUN; D ignored.
REQ-022 CLEAR: SHALL last exactly CLR_W cycles then return to STOP; all button events to the channel SHALL be ignored during CLEAR.
REQ-023 Expiry: expire[i] high while channel i in RUN or LAP with dir_down[i]=1 SHALL force STOP and set alarm[i] at the same edge, with priority over any simultaneous button event.
REQ-024 expire[i] SHALL be ignored when dir_down[i]=0 or channel i is in STOP or CLEAR.
REQ-025 alarm[i] SHALL clear on the next R or L event to channel i (the event is also acted on normally); expiry and clear in the same cycle -> alarm stays set.
REQ-026 dir_down SHALL be preserved through CLEAR, RUN and LAP.
REQ-027 A btn_U event in the same cycle as an L/R/D event SHALL apply the L/R/D event to the old ch_sel.

Reset
REQ-028 On rst: all channels STOP; run, clear, lap_hold, dir_down, alarm = 0; ch_sel = 0.
REQ-029 On rst, button history registers SHALL be set to 1 so a button held across reset release produces no event.
REQ-030 rst asserted mid-CLEAR or mid-LAP SHALL abort immediately; clear and lap_hold drop asynchronously.

Verification
REQ-031 Reset, pulse btn_R one cycle -> run[0]=1 one edge later; second btn_R pulse -> run[0]=0; run[1] stays 0 throughout.
REQ-032 CLR_W=3, channel 0 STOP, btn_L pulse -> clear[0]=1 for exactly 3 cycles, then STOP; btn_R pressed during clear -> ignored, run[0] stays 0.
REQ-033 RUN, btn_L -> lap_hold[0]=1, run[0]=1; btn_L -> lap_hold[0]=0; btn_L again, then btn_R -> run[0]=0, lap_hold[0]=0.
REQ-034 N_CH=3: four btn_U pulses -> ch_sel 1,2,0,1; start channel 1, select 2, start 2 -> run=3'b110.
REQ-035 STOP, btn_D -> dir_down[0]=1; btn_R -> RUN; expire[0]=1 with simultaneous btn_L -> STOP, alarm[0]=1, lap_hold[0]=0; next btn_R -> alarm[0]=0, run[0]=1.
REQ-036 Hold btn_R high across rst deassertion for 10 cycles -> no event, run=0; release and press -> run[0]=1.
